// File: rtl/gerador_tick.sv
// Programmable tick generator: single-cycle max_tick every N enabled clocks, square wave and wrapping scan index.
// Optional active-low anode decode of scan_idx is built when GERADOR_TICK_ANODO_EN is defined.
module gerador_tick #(
  parameter int          WIDTH       = 17,
  parameter int unsigned DIV_DEFAULT = 125000,
  parameter int          NUM_CH      = 4,
  localparam int         CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_load,
  input  logic [WIDTH-1:0]  div_value,
  output logic              max_tick,
  output logic              clk_out,
  output logic [CH_W-1:0]   scan_idx,
  output logic [WIDTH-1:0]  div_atual,
`ifdef GERADOR_TICK_ANODO_EN
  output logic [NUM_CH-1:0] anodo,
`endif
  output logic              load_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  logic [WIDTH-1:0] cont;
  logic             terminal;
  logic             load_ok;
  logic             load_zero;
  logic [CH_W-1:0]  scan_next;

  assign terminal  = (cont == div_atual);
  assign load_ok   = div_load && (div_value != '0);
  assign load_zero = div_load && (div_value == '0);
  // Explicit wrap keeps the index below NUM_CH even when NUM_CH is not a power of two.
  assign scan_next = (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;

`ifdef GERADOR_TICK_ANODO_EN
  function automatic logic [NUM_CH-1:0] decode_anodo(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] dec;
    dec = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == CH_W'(i)) dec[i] = 1'b0;
    end
    return dec;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cont      <= ONE;
      div_atual <= DIV_RST;
      max_tick  <= 1'b0;
      clk_out   <= 1'b0;
      scan_idx  <= '0;
      load_err  <= 1'b0;
`ifdef GERADOR_TICK_ANODO_EN
      anodo     <= decode_anodo('0);
`endif
    end else begin
      load_err <= load_zero;
      // A valid load restarts the period and suppresses any tick due on this edge.
      if (load_ok) begin
        div_atual <= div_value;
        cont      <= ONE;
        max_tick  <= 1'b0;
      end else if (en) begin
        if (terminal) begin
          cont     <= ONE;
          max_tick <= 1'b1;
          clk_out  <= ~clk_out;
          scan_idx <= scan_next;
`ifdef GERADOR_TICK_ANODO_EN
          anodo    <= decode_anodo(scan_next);
`endif
        end else begin
          cont     <= cont + ONE;
          max_tick <= 1'b0;
        end
      end else begin
        max_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gerador_tick.sv
// Bench for gerador_tick: table of hand-derived vectors for a NUM_CH=4 and a NUM_CH=3 instance, checked through a scoreboard queue.
module tb_gerador_tick;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Instance A: DIV_DEFAULT=4, NUM_CH=4
  logic        rst4 = 1'b1, en4 = 1'b0, ld4 = 1'b0;
  logic [16:0] dv4 = '0;
  logic        mt4, co4, le4;
  logic [1:0]  sc4;
  logic [16:0] div4;
`ifdef GERADOR_TICK_ANODO_EN
  logic [3:0]  an4;
`endif

  // Instance B: DIV_DEFAULT=1, NUM_CH=3
  logic        rst3 = 1'b1, en3 = 1'b0, ld3 = 1'b0;
  logic [16:0] dv3 = '0;
  logic        mt3, co3, le3;
  logic [1:0]  sc3;
  logic [16:0] div3;
`ifdef GERADOR_TICK_ANODO_EN
  logic [2:0]  an3;
`endif

  gerador_tick #(.WIDTH(17), .DIV_DEFAULT(4), .NUM_CH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .div_load(ld4), .div_value(dv4),
    .max_tick(mt4), .clk_out(co4), .scan_idx(sc4), .div_atual(div4),
`ifdef GERADOR_TICK_ANODO_EN
    .anodo(an4),
`endif
    .load_err(le4)
  );

  gerador_tick #(.WIDTH(17), .DIV_DEFAULT(1), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .div_load(ld3), .div_value(dv3),
    .max_tick(mt3), .clk_out(co3), .scan_idx(sc3), .div_atual(div3),
`ifdef GERADOR_TICK_ANODO_EN
    .anodo(an3),
`endif
    .load_err(le3)
  );

  typedef struct {
    logic        sel;
    logic        rst, en, ld;
    logic [16:0] dv;
    logic        mt, co;
    logic [1:0]  sc;
    logic [16:0] div;
    logic        le;
    logic [2:0]  an;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic s, input logic r, input logic e, input logic l,
                              input logic [16:0] dv, input logic m, input logic c,
                              input logic [1:0] sc, input logic [16:0] dvs,
                              input logic le, input logic [2:0] an);
    vec_t v;
    v.sel = s; v.rst = r; v.en = e; v.ld = l; v.dv = dv;
    v.mt = m; v.co = c; v.sc = sc; v.div = dvs; v.le = le; v.an = an;
    vecs.push_back(v);
  endfunction

  function automatic void zeros(input int n, input logic c, input logic [1:0] sc, input logic [16:0] d);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0, c, sc, d, 1'b0, 3'b000);
  endfunction

  function automatic void hold(input int n, input logic c, input logic [1:0] sc, input logic [16:0] d);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0, c, sc, d, 1'b0, 3'b000);
  endfunction

  function automatic void tick(input logic c, input logic [1:0] sc, input logic [16:0] d);
    add(1'b0, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, c, sc, d, 1'b0, 3'b000);
  endfunction

  task automatic check(input vec_t e, input int idx);
    logic        m, c, le;
    logic [1:0]  sc;
    logic [16:0] d;
    logic [2:0]  an;
    logic        bad;
    if (e.sel == 1'b0) begin
      m = mt4; c = co4; sc = sc4; d = div4; le = le4; an = 3'b000;
    end else begin
      m = mt3; c = co3; sc = sc3; d = div3; le = le3;
`ifdef GERADOR_TICK_ANODO_EN
      an = an3;
`else
      an = 3'b000;
`endif
    end
    bad = (m !== e.mt) || (c !== e.co) || (sc !== e.sc) || (d !== e.div) || (le !== e.le);
`ifdef GERADOR_TICK_ANODO_EN
    if (e.sel == 1'b1 && an !== e.an) bad = 1'b1;
`endif
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL vec%0d inst%0d: got mt=%b co=%b sc=%0d div=%0d le=%b an=%b, want mt=%b co=%b sc=%0d div=%0d le=%b an=%b",
               idx, e.sel ? 3 : 4, m, c, sc, d, le, an, e.mt, e.co, e.sc, e.div, e.le, e.an);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v, e;

    // Instance A: reset, four ticks at N=4
    add(1'b0, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 2'd0, 17'd4, 1'b0, 3'b000);
    zeros(3, 1'b0, 2'd0, 17'd4); tick(1'b1, 2'd1, 17'd4);
    zeros(3, 1'b1, 2'd1, 17'd4); tick(1'b0, 2'd2, 17'd4);
    zeros(3, 1'b0, 2'd2, 17'd4); tick(1'b1, 2'd3, 17'd4);
    zeros(3, 1'b1, 2'd3, 17'd4); tick(1'b0, 2'd0, 17'd4);
    // en low for 5 cycles with cont=2
    zeros(1, 1'b0, 2'd0, 17'd4);
    hold(5, 1'b0, 2'd0, 17'd4);
    zeros(2, 1'b0, 2'd0, 17'd4); tick(1'b1, 2'd1, 17'd4);
    // load of zero: error pulse, cadence unchanged
    add(1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 1'b0, 1'b1, 2'd1, 17'd4, 1'b1, 3'b000);
    zeros(2, 1'b1, 2'd1, 17'd4); tick(1'b0, 2'd2, 17'd4);
    // load 6 on the terminal-count edge
    zeros(3, 1'b0, 2'd2, 17'd4);
    add(1'b0, 1'b0, 1'b1, 1'b1, 17'd6, 1'b0, 1'b0, 2'd2, 17'd6, 1'b0, 3'b000);
    zeros(5, 1'b0, 2'd2, 17'd6); tick(1'b1, 2'd3, 17'd6);
    zeros(5, 1'b1, 2'd3, 17'd6); tick(1'b0, 2'd0, 17'd6);
    // load 1: tick every cycle, scan wraps 3->0
    add(1'b0, 1'b0, 1'b1, 1'b1, 17'd1, 1'b0, 1'b0, 2'd0, 17'd1, 1'b0, 3'b000);
    tick(1'b1, 2'd1, 17'd1); tick(1'b0, 2'd2, 17'd1);
    tick(1'b1, 2'd3, 17'd1); tick(1'b0, 2'd0, 17'd1);
    // reset overrides a simultaneous load
    add(1'b0, 1'b1, 1'b1, 1'b1, 17'd7, 1'b0, 1'b0, 2'd0, 17'd4, 1'b0, 3'b000);
    // load while en low still takes effect
    add(1'b0, 1'b0, 1'b0, 1'b1, 17'd5, 1'b0, 1'b0, 2'd0, 17'd5, 1'b0, 3'b000);
    zeros(4, 1'b0, 2'd0, 17'd5); tick(1'b1, 2'd1, 17'd5);
    // zero load on terminal count: tick still issued, error flagged
    zeros(4, 1'b1, 2'd1, 17'd5);
    add(1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 1'b1, 1'b0, 2'd2, 17'd5, 1'b1, 3'b000);
    zeros(1, 1'b0, 2'd2, 17'd5);

    // Instance B: NUM_CH=3, N=1 after reset
    add(1'b1, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 2'd0, 17'd1, 1'b0, 3'b110);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 2'd1, 17'd1, 1'b0, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, 1'b0, 2'd2, 17'd1, 1'b0, 3'b011);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 2'd0, 17'd1, 1'b0, 3'b110);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, 1'b0, 2'd1, 17'd1, 1'b0, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b1, 17'd3, 1'b0, 1'b0, 2'd1, 17'd3, 1'b0, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 2'd1, 17'd3, 1'b0, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 2'd1, 17'd3, 1'b0, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b1, 1'b1, 2'd2, 17'd3, 1'b0, 3'b011);
    add(1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b1, 2'd2, 17'd3, 1'b0, 3'b011);
    // reset mid-period restores defaults
    add(1'b1, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 2'd0, 17'd1, 1'b0, 3'b110);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      if (v.sel == 1'b0) begin
        rst4 = v.rst; en4 = v.en; ld4 = v.ld; dv4 = v.dv;
        rst3 = 1'b1;
      end else begin
        rst3 = v.rst; en3 = v.en; ld3 = v.ld; dv3 = v.dv;
        rst4 = 1'b1;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: queue empty at vec%0d, got size 0, want 1", i);
      end else begin
        e = exp_q.pop_front();
        check(e, i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
